// File: rtl/reorder_buffer_param_if.sv
// Allocation, writeback, commit and occupancy signals of the reorder buffer.
// master drives allocations/writebacks; slave is the buffer itself.
interface reorder_buffer_param_if #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [4:0]        alloc_rd;
  logic [DATA_W-1:0] alloc_value;
  logic [IDX_W-1:0]  alloc_idx;

  logic              wb0_valid;
  logic [IDX_W-1:0]  wb0_idx;
  logic [DATA_W-1:0] wb0_value;
  logic              wb1_valid;
  logic [IDX_W-1:0]  wb1_idx;
  logic [DATA_W-1:0] wb1_value;

  logic              commit_valid;
  logic [IDX_W-1:0]  commit_idx;
  logic [4:0]        commit_rd;
  logic [DATA_W-1:0] commit_value;

  logic              full;
  logic              empty;
  logic [IDX_W:0]    count;

  modport master (
    output alloc_valid, alloc_ready, alloc_rd, alloc_value,
    output wb0_valid, wb0_idx, wb0_value, wb1_valid, wb1_idx, wb1_value,
    input  alloc_idx, commit_valid, commit_idx, commit_rd, commit_value,
    input  full, empty, count
  );

  modport slave (
    input  alloc_valid, alloc_ready, alloc_rd, alloc_value,
    input  wb0_valid, wb0_idx, wb0_value, wb1_valid, wb1_idx, wb1_value,
    output alloc_idx, commit_valid, commit_idx, commit_rd, commit_value,
    output full, empty, count
  );
endinterface

// File: rtl/reorder_buffer_param.sv
// In-order commit reorder buffer: circular queue, two writeback ports, one commit per edge.
// Optional squash via flush_in when ROB_FLUSH_EN is defined; otherwise flush_in is ignored.
module reorder_buffer_param #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  reorder_buffer_param_if.slave  rob
);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE  = (IDX_W+1)'(1);

  logic [IDX_W:0]    head, tail, count;
  logic [DEPTH-1:0]  busy, ready;
  logic [4:0]        rd_q  [DEPTH];
  logic [DATA_W-1:0] val_q [DEPTH];

  logic              commit_valid;
  logic [IDX_W-1:0]  commit_idx;
  logic [4:0]        commit_rd;
  logic [DATA_W-1:0] commit_value;

  logic [IDX_W-1:0]  hidx, tidx;
  logic              full, do_flush, alloc_go, commit_go, wb0_go, wb1_go;

`ifdef ROB_FLUSH_EN
  assign do_flush = flush_in;
`else
  logic unused_flush;
  assign unused_flush = flush_in;
  assign do_flush     = 1'b0;
`endif

  assign hidx  = head[IDX_W-1:0];
  assign tidx  = tail[IDX_W-1:0];
  assign count = tail - head;
  assign full  = (count == FULL_CNT);

  assign alloc_go  = rdy_in && !do_flush && rob.alloc_valid && !full;
  assign commit_go = rdy_in && !do_flush && busy[hidx] && ready[hidx];
  assign wb0_go    = rdy_in && !do_flush && rob.wb0_valid && busy[rob.wb0_idx];
  assign wb1_go    = rdy_in && !do_flush && rob.wb1_valid && busy[rob.wb1_idx];

  assign rob.alloc_idx    = tidx;
  assign rob.full         = full;
  assign rob.empty        = (count == '0);
  assign rob.count        = count;
  assign rob.commit_valid = commit_valid;
  assign rob.commit_idx   = commit_idx;
  assign rob.commit_rd    = commit_rd;
  assign rob.commit_value = commit_value;

  // Control state; commit clears head after any writeback to it so a retiring entry stays freed.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head         <= '0;
      tail         <= '0;
      busy         <= '0;
      ready        <= '0;
      commit_valid <= 1'b0;
      commit_idx   <= '0;
      commit_rd    <= '0;
      commit_value <= '0;
    end else begin
      commit_valid <= 1'b0;
      if (rdy_in && do_flush) begin
        head  <= '0;
        tail  <= '0;
        busy  <= '0;
        ready <= '0;
      end else begin
        if (wb0_go) ready[rob.wb0_idx] <= 1'b1;
        if (wb1_go) ready[rob.wb1_idx] <= 1'b1;
        if (commit_go) begin
          busy[hidx]   <= 1'b0;
          ready[hidx]  <= 1'b0;
          head         <= head + PTR_ONE;
          commit_valid <= 1'b1;
          commit_idx   <= hidx;
          commit_rd    <= rd_q[hidx];
          commit_value <= val_q[hidx];
        end
        if (alloc_go) begin
          busy[tidx]  <= 1'b1;
          ready[tidx] <= rob.alloc_ready;
          tail        <= tail + PTR_ONE;
        end
      end
    end
  end

  // Payload storage is not reset; busy gates every use of it. wb1 written last so it wins.
  always_ff @(posedge clk_in) begin
    if (wb0_go) val_q[rob.wb0_idx] <= rob.wb0_value;
    if (wb1_go) val_q[rob.wb1_idx] <= rob.wb1_value;
    if (alloc_go) begin
      val_q[tidx] <= rob.alloc_value;
      rd_q[tidx]  <= rob.alloc_rd;
    end
  end
endmodule

// File: tb/tb_reorder_buffer_param.sv
// Scoreboarded bench: allocations push (idx, rd), commits pop and compare against a value model.
module tb_reorder_buffer_param;
  localparam int DEPTH = 16, IDX_W = 4, DATA_W = 32;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [4:0]       rd;
  } sb_t;

  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush_in = 1'b0;
  int   n_checks = 0, n_pass = 0;
  sb_t  sbq[$];
  logic [DATA_W-1:0] mdl_val [DEPTH];

  reorder_buffer_param_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

  reorder_buffer_param #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in), .rob(bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Commit monitor: every commit must match the oldest outstanding allocation.
  always @(negedge clk_in) begin
    if (!rst_in && bus.commit_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_commit", {59'd0, bus.commit_idx}, 64'hdead);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("sb_commit_idx", {60'd0, bus.commit_idx}, {60'd0, e.idx});
        check("sb_commit_rd", {59'd0, bus.commit_rd}, {59'd0, e.rd});
        check("sb_commit_value", {32'd0, bus.commit_value}, {32'd0, mdl_val[e.idx]});
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid = 1'b0; bus.alloc_ready = 1'b0; bus.alloc_rd = '0; bus.alloc_value = '0;
    bus.wb0_valid = 1'b0; bus.wb0_idx = '0; bus.wb0_value = '0;
    bus.wb1_valid = 1'b0; bus.wb1_idx = '0; bus.wb1_value = '0;
    flush_in = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    sbq.delete();
    tick();
    check("rst_empty", {63'd0, bus.empty}, 64'd1);
    check("rst_full", {63'd0, bus.full}, 64'd0);
    check("rst_count", {59'd0, bus.count}, 64'd0);
    check("rst_commit_valid", {63'd0, bus.commit_valid}, 64'd0);
    rst_in = 1'b0;
  endtask

  // Drive one allocation for the next edge and record it as expected.
  task automatic alloc(input logic rdy, input logic [4:0] rd, input logic [31:0] val);
    sb_t e;
    e.idx = bus.alloc_idx;
    e.rd  = rd;
    sbq.push_back(e);
    mdl_val[e.idx] = val;
    bus.alloc_valid = 1'b1; bus.alloc_ready = rdy; bus.alloc_rd = rd; bus.alloc_value = val;
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic wb0(input logic [IDX_W-1:0] idx, input logic [31:0] val);
    bus.wb0_valid = 1'b1; bus.wb0_idx = idx; bus.wb0_value = val;
    mdl_val[idx] = val;
    tick();
    bus.wb0_valid = 1'b0;
  endtask

  initial begin
    // Single pre-resolved allocation commits one edge later.
    do_reset();
    check("first_alloc_idx", {60'd0, bus.alloc_idx}, 64'd0);
    alloc(1'b1, 5'd5, 32'h1234_5678);
    check("no_commit_same_edge", {63'd0, bus.commit_valid}, 64'd0);
    tick();
    check("commit_valid", {63'd0, bus.commit_valid}, 64'd1);
    check("commit_rd", {59'd0, bus.commit_rd}, 64'd5);
    check("commit_value", {32'd0, bus.commit_value}, 64'h1234_5678);
    check("empty_after", {63'd0, bus.empty}, 64'd1);

    // Fill to full, reject 17th, then commit-vs-alloc at the full boundary.
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(1'b0, 5'(i), 32'(i));
    check("full_flag", {63'd0, bus.full}, 64'd1);
    check("full_count", {59'd0, bus.count}, 64'd16);
    bus.alloc_valid = 1'b1; bus.alloc_ready = 1'b0; bus.alloc_rd = 5'd16; bus.alloc_value = 32'hAAAA;
    tick();
    check("reject_count", {59'd0, bus.count}, 64'd16);
    check("reject_alloc_idx", {60'd0, bus.alloc_idx}, 64'd0);
    bus.wb0_valid = 1'b1; bus.wb0_idx = 4'd0; bus.wb0_value = 32'h100;
    mdl_val[0] = 32'h100;
    tick();
    bus.wb0_valid = 1'b0;
    check("wb_head_no_commit_yet", {63'd0, bus.commit_valid}, 64'd0);
    tick();
    check("full_commit_valid", {63'd0, bus.commit_valid}, 64'd1);
    check("full_commit_count", {59'd0, bus.count}, 64'd15);
    check("wrapped_alloc_idx", {60'd0, bus.alloc_idx}, 64'd0);
    begin
      sb_t e;
      e.idx = 4'd0; e.rd = 5'd16;
      sbq.push_back(e);
    end
    tick();
    bus.alloc_valid = 1'b0;
    mdl_val[0] = 32'hAAAA;
    check("wrapped_alloc_count", {59'd0, bus.count}, 64'd16);
    // Drain, with a same-cycle dual writeback on entry 3 where wb1 must win.
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 3) begin
        bus.wb1_valid = 1'b1; bus.wb1_idx = 4'd3; bus.wb1_value = 32'hB;
        bus.wb0_valid = 1'b1; bus.wb0_idx = 4'd3; bus.wb0_value = 32'hA;
        mdl_val[3] = 32'hB;
        tick();
        bus.wb0_valid = 1'b0; bus.wb1_valid = 1'b0;
      end else begin
        wb0(4'(k % DEPTH), 32'(k * 3));
      end
    end
    tick(); tick();
    check("drain_empty", {63'd0, bus.empty}, 64'd1);

    // Out-of-order writebacks, in-order commit.
    do_reset();
    for (int i = 0; i < 3; i++) alloc(1'b0, 5'(i + 8), 32'hFFFF_0000);
    wb0(4'd2, 32'h22);
    check("ooo_no_commit_2", {63'd0, bus.commit_valid}, 64'd0);
    wb0(4'd1, 32'h11);
    check("ooo_no_commit_1", {63'd0, bus.commit_valid}, 64'd0);
    wb0(4'd0, 32'h00);
    check("ooo_no_commit_0", {63'd0, bus.commit_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ooo_commit_valid", {63'd0, bus.commit_valid}, 64'd1);
      check("ooo_commit_idx", {60'd0, bus.commit_idx}, 64'(i));
    end
    tick();
    check("ooo_done", {63'd0, bus.commit_valid}, 64'd0);

    // Stall: rdy_in low freezes writebacks and commits.
    do_reset();
    alloc(1'b0, 5'd7, 32'h77);
    rdy_in = 1'b0;
    bus.wb0_valid = 1'b1; bus.wb0_idx = 4'd0; bus.wb0_value = 32'h99;
    tick();
    bus.wb0_valid = 1'b0;
    rdy_in = 1'b1;
    tick(); tick();
    check("stall_no_commit", {63'd0, bus.commit_valid}, 64'd0);
    check("stall_count", {59'd0, bus.count}, 64'd1);
    wb0(4'd0, 32'h55);
    tick();
    check("stall_late_commit", {63'd0, bus.commit_valid}, 64'd1);

    // Flush with a simultaneous writeback to head.
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1'b0, 5'(i), 32'(i + 100));
    flush_in = 1'b1;
    bus.wb0_valid = 1'b1; bus.wb0_idx = 4'd0; bus.wb0_value = 32'hF0;
    tick();
    flush_in = 1'b0;
    bus.wb0_valid = 1'b0;
`ifdef ROB_FLUSH_EN
    sbq.delete();
    check("flush_empty", {63'd0, bus.empty}, 64'd1);
    tick();
    check("flush_no_commit", {63'd0, bus.commit_valid}, 64'd0);
`else
    mdl_val[0] = 32'hF0;
    check("noflush_count", {59'd0, bus.count}, 64'd5);
    for (int i = 1; i < 5; i++) wb0(4'(i), 32'(i * 7));
    tick(); tick();
    check("noflush_drained", {63'd0, bus.empty}, 64'd1);
`endif
    tick();
    check("sb_all_committed", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
